// File: rtl/row_instr_loader_pkg.sv
// Shared types and constants for the row instruction loader.
//   - loader_state_e : top-level sequencing states
//   - wait_phase_e   : internal phase of the ret_waiter
//   - instr_word_t   : packed {hops, addr, data}, also used by the host-side
//                      program buffer, so field order must stay fixed
//   - sat_inc16      : saturating 16-bit increment for the word counter
package row_instr_loader_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_HOPS_WIDTH   = 4;
    localparam int DEF_RET_TIMEOUT  = 1024;
    localparam int WORDS_SENT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_CALL      = 3'd2,
        ST_WAIT_LOW  = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_DONE      = 3'd5
    } loader_state_e;

    typedef enum logic [1:0] {
        WP_IDLE = 2'd0,
        WP_LOW  = 2'd1,
        WP_HIGH = 2'd2
    } wait_phase_e;

    typedef struct packed {
        logic [DEF_HOPS_WIDTH-1:0] hops;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } instr_word_t;

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [WORDS_SENT_WIDTH-1:0] sat_inc16(
        input logic [WORDS_SENT_WIDTH-1:0] v
    );
        logic [WORDS_SENT_WIDTH-1:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/row_instr_loader_ret_waiter.sv
// ret_waiter: registers the row's ret input and tracks the call handshake.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   go          - one-cycle pulse in the call cycle; arms the waiter
//   ret         - raw ret from column 0 of the ret chain
//   fell        - registered ret seen low while waiting for the fall
//   finished    - registered ret seen high again after the fall
//   timeout     - ret never fell within RET_TIMEOUT cycles of the call
// All three outputs are single-cycle strobes decoded from registered state.
module ret_waiter
    import row_instr_loader_pkg::*;
#(
    parameter int RET_TIMEOUT = DEF_RET_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    input  logic ret,
    output logic fell,
    output logic finished,
    output logic timeout
);

    localparam int CW = $clog2(RET_TIMEOUT) + 1;

    wait_phase_e     phase_r;
    wait_phase_e     phase_nx_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nx_s;
    logic            ret_r;

    // ret travels combinationally through every cell, so it is retimed here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_r <= 1'b0;
        end else begin
            ret_r <= ret;
        end
    end

    // Phase and timeout counter update; strobes decoded from current phase.
    // The counter starts at RET_TIMEOUT-1 and timeout fires on the step that
    // would take it from 1 to 0, so the error becomes visible exactly
    // RET_TIMEOUT cycles after the call cycle.
    always_comb begin
        phase_nx_s = phase_r;
        cnt_nx_s   = cnt_r;
        fell       = 1'b0;
        finished   = 1'b0;
        timeout    = 1'b0;
        case (phase_r)
            WP_IDLE: begin
                if (go) begin
                    phase_nx_s = WP_LOW;
                    cnt_nx_s   = CW'(RET_TIMEOUT - 1);
                end else begin
                    cnt_nx_s   = '0;
                end
            end
            WP_LOW: begin
                if (!ret_r) begin
                    fell       = 1'b1;
                    phase_nx_s = WP_HIGH;
                    cnt_nx_s   = '0;
                end else if (cnt_r <= CW'(1)) begin
                    timeout    = 1'b1;
                    phase_nx_s = WP_IDLE;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = cnt_r - CW'(1);
                end
            end
            WP_HIGH: begin
                if (ret_r) begin
                    finished   = 1'b1;
                    phase_nx_s = WP_IDLE;
                end else begin
                    phase_nx_s = WP_HIGH;
                end
            end
            default: begin
                phase_nx_s = WP_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Phase and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_r <= WP_IDLE;
            cnt_r   <= '0;
        end else begin
            phase_r <= phase_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

endmodule

// File: rtl/row_instr_loader.sv
// row_instr_loader: initiator end of one fabric row's instruction/call chain.
// Streams host instruction words onto the chain, pulses call, waits for the
// row's ret to fall and rise again, then reports completion.
// Ports:
//   clk, rst_n                   - clock, synchronous active-low reset
//   start / busy / done          - sequence control and status
//   err_timeout                  - sticky: ret never fell after call
//   prog_valid/ready/data/addr/hops/last - host word stream
//   instr_data/addr/hops/en_out  - column-0 chain inputs (en qualifies data)
//   call / ret                   - column-0 call and ret chain
//   words_sent                   - words issued this sequence, saturating
module row_instr_loader
    import row_instr_loader_pkg::*;
#(
    parameter int INSTR_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INSTR_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INSTR_HOPS_WIDTH = DEF_HOPS_WIDTH,
    parameter int RET_TIMEOUT      = DEF_RET_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err_timeout,
    input  logic                        prog_valid,
    output logic                        prog_ready,
    input  logic [INSTR_DATA_WIDTH-1:0] prog_data,
    input  logic [INSTR_ADDR_WIDTH-1:0] prog_addr,
    input  logic [INSTR_HOPS_WIDTH-1:0] prog_hops,
    input  logic                        prog_last,
    output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
    output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
    output logic                        instr_en_out,
    output logic                        call,
    input  logic                        ret,
    output logic [WORDS_SENT_WIDTH-1:0] words_sent
);

    loader_state_e state_r;
    loader_state_e state_nx_s;
    logic          hs_s;
    logic          go_s;
    logic          start_acc_s;
    logic          fell_s;
    logic          finished_s;
    logic          timeout_s;

    // prog_ready is registered from the next state, so it equals "in LOAD".
    assign hs_s        = prog_valid & prog_ready;
    assign go_s        = (state_r == ST_CALL);
    assign start_acc_s = (state_r == ST_IDLE) & start;

    ret_waiter #(
        .RET_TIMEOUT (RET_TIMEOUT)
    ) u_ret_waiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go_s),
        .ret      (ret),
        .fell     (fell_s),
        .finished (finished_s),
        .timeout  (timeout_s)
    );

    // Next-state logic of the top sequencing FSM.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s && prog_last) begin
                    state_nx_s = ST_CALL;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_CALL: begin
                state_nx_s = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (timeout_s) begin
                    state_nx_s = ST_DONE;
                end else if (fell_s) begin
                    state_nx_s = ST_WAIT_HIGH;
                end else begin
                    state_nx_s = ST_WAIT_LOW;
                end
            end
            ST_WAIT_HIGH: begin
                if (finished_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WAIT_HIGH;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            call       <= 1'b0;
            prog_ready <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            busy       <= (state_nx_s != ST_IDLE);
            done       <= (state_nx_s == ST_DONE);
            call       <= (state_nx_s == ST_CALL);
            prog_ready <= (state_nx_s == ST_LOAD);
        end
    end

    // Chain datapath: capture on handshake, hold otherwise; en marks new words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_data_out <= '0;
            instr_addr_out <= '0;
            instr_hops_out <= '0;
            instr_en_out   <= 1'b0;
        end else begin
            instr_en_out <= hs_s;
            if (hs_s) begin
                instr_data_out <= prog_data;
                instr_addr_out <= prog_addr;
                instr_hops_out <= prog_hops;
            end else begin
                instr_data_out <= instr_data_out;
                instr_addr_out <= instr_addr_out;
                instr_hops_out <= instr_hops_out;
            end
        end
    end

    // Word counter and sticky timeout flag; both cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_sent  <= 16'd0;
            err_timeout <= 1'b0;
        end else if (start_acc_s) begin
            words_sent  <= 16'd0;
            err_timeout <= 1'b0;
        end else begin
            if (hs_s) begin
                words_sent <= sat_inc16(words_sent);
            end else begin
                words_sent <= words_sent;
            end
            if ((state_r == ST_WAIT_LOW) && timeout_s) begin
                err_timeout <= 1'b1;
            end else begin
                err_timeout <= err_timeout;
            end
        end
    end

endmodule

// File: tb/tb_row_instr_loader.sv
// Self-checking bench for row_instr_loader. Expected behaviour is derived from
// cycle arithmetic relative to handshake, call and ret-rise events.
module tb_row_instr_loader;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int HW = 4;
    localparam int RT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          prog_valid;
    logic          prog_ready;
    logic [DW-1:0] prog_data;
    logic [AW-1:0] prog_addr;
    logic [HW-1:0] prog_hops;
    logic          prog_last;
    logic [DW-1:0] instr_data_out;
    logic [AW-1:0] instr_addr_out;
    logic [HW-1:0] instr_hops_out;
    logic          instr_en_out;
    logic          call;
    logic          ret;
    logic [15:0]   words_sent;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] q_d[$];
    logic [AW-1:0] q_a[$];
    logic [HW-1:0] q_h[$];
    logic [DW-1:0] last_d;
    logic [AW-1:0] last_a;
    logic [HW-1:0] last_h;

    always #5 clk = ~clk;

    row_instr_loader #(
        .INSTR_DATA_WIDTH (DW),
        .INSTR_ADDR_WIDTH (AW),
        .INSTR_HOPS_WIDTH (HW),
        .RET_TIMEOUT      (RT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout),
        .prog_valid     (prog_valid),
        .prog_ready     (prog_ready),
        .prog_data      (prog_data),
        .prog_addr      (prog_addr),
        .prog_hops      (prog_hops),
        .prog_last      (prog_last),
        .instr_data_out (instr_data_out),
        .instr_addr_out (instr_addr_out),
        .instr_hops_out (instr_hops_out),
        .instr_en_out   (instr_en_out),
        .call           (call),
        .ret            (ret),
        .words_sent     (words_sent)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic [HW-1:0] h);
        q_d.push_back(d);
        q_a.push_back(a);
        q_h.push_back(h);
    endtask

    // Streams the queued program. gap_mode: 0 back-to-back, 1 alternate, 2 random.
    task automatic run_load(input int gap_mode);
        int  n;
        int  sent;
        int  c;
        bit  v;
        n    = q_d.size();
        sent = 0;
        c    = 0;
        while (sent < n && c < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = ($urandom_range(0, 99) >= 30);
            endcase
            prog_valid = v;
            prog_data  = v ? q_d[sent] : DW'($urandom);
            prog_addr  = v ? q_a[sent] : AW'($urandom);
            prog_hops  = v ? q_h[sent] : HW'($urandom);
            prog_last  = v && (sent == n - 1);
            chk("ready_in_load", prog_ready, 1'b1);
            tick();
            chk("en", instr_en_out, v);
            if (v) begin
                last_d = q_d[sent];
                last_a = q_a[sent];
                last_h = q_h[sent];
                sent++;
            end
            chk("data", instr_data_out, last_d);
            chk("addr", instr_addr_out, last_a);
            chk("hops", instr_hops_out, last_h);
            chk("words_sent", words_sent, sent);
            chk("call_vs_last", call, (v && sent == n));
            c++;
        end
        chk("load_bounded", sent, n);
        prog_valid = 1'b1;
        prog_last  = 1'b0;
        prog_data  = DW'($urandom);
    endtask

    // Drives ret after the call cycle; a start is pulsed while waiting for rise.
    task automatic run_wait(input int low_len, input bit to_mode, input int nwords);
        int exp_done;
        int j;
        bit seen;
        exp_done = to_mode ? RT : low_len + 2;
        j        = 0;
        seen     = 1'b0;
        while (!seen && j < exp_done + 20) begin
            ret   = (!to_mode && j < low_len) ? 1'b0 : 1'b1;
            start = (!to_mode && j == low_len + 1);
            tick();
            j++;
            chk("ready_outside_load", prog_ready, 1'b0);
            chk("en_outside_load", instr_en_out, 1'b0);
            chk("call_once", call, 1'b0);
            chk("done_time", done, (j == exp_done));
            chk("err_time", err_timeout, (to_mode && j >= exp_done));
            chk("busy_wait", busy, 1'b1);
            if (done) begin
                seen = 1'b1;
            end
        end
        start = 1'b0;
        ret   = 1'b1;
        chk("done_seen", seen, 1'b1);
        chk("words_sent_final", words_sent, nwords);
        tick();
        chk("idle_after_done", busy, 1'b0);
        chk("done_pulse_1", done, 1'b0);
        chk("err_sticky", err_timeout, to_mode);
        tick();
        chk("start_in_wait_ignored", busy, 1'b0);
    endtask

    task automatic run_seq(input int gap_mode, input int low_len, input bit to_mode);
        int n;
        n = q_d.size();
        chk("idle_before_start", busy, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("ready_after_start", prog_ready, 1'b1);
        chk("err_cleared", err_timeout, 1'b0);
        chk("ws_cleared", words_sent, 16'd0);
        run_load(gap_mode);
        run_wait(low_len, to_mode, n);
        q_d.delete();
        q_a.delete();
        q_h.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        prog_valid = 1'b1;
        prog_last  = 1'b1;
        prog_data  = 32'hFFFF_FFFF;
        prog_addr  = 4'hF;
        prog_hops  = 4'hF;
        ret        = 1'b1;
        last_d     = 32'd0;
        last_a     = 4'd0;
        last_h     = 4'd0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_ready", prog_ready, 1'b0);
        chk("rst_data", instr_data_out, 32'd0);
        chk("rst_addr", instr_addr_out, 4'd0);
        chk("rst_hops", instr_hops_out, 4'd0);
        chk("rst_en", instr_en_out, 1'b0);
        chk("rst_call", call, 1'b0);
        chk("rst_ws", words_sent, 16'd0);

        rst_n = 1'b1;
        tick();
        chk("idle_valid_ignored_ready", prog_ready, 1'b0);
        chk("idle_valid_ignored_en", instr_en_out, 1'b0);

        // Directed: three back-to-back words, ret low for 5 cycles.
        push_word(32'h0000_000A, 4'd3, 4'd0);
        push_word(32'h0000_000B, 4'd5, 4'd1);
        push_word(32'h0000_000C, 4'd7, 4'd2);
        run_seq(0, 5, 1'b0);

        // ret never falls: timeout path.
        push_word(32'h1234_5678, 4'd1, 4'd9);
        run_seq(0, 0, 1'b1);

        // Valid toggling 1,0,1; start clears the sticky error.
        push_word(32'hDEAD_BEEF, 4'd2, 4'd4);
        push_word(32'hCAFE_F00D, 4'd6, 4'd5);
        run_seq(1, 3, 1'b0);

        // Single-cycle ret glitch counts as a fall.
        push_word(32'h0BAD_F00D, 4'd8, 4'd3);
        run_seq(2, 1, 1'b0);

        // Randomized sequences.
        for (int s = 0; s < 8; s++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                push_word(DW'($urandom), AW'($urandom), HW'($urandom));
            end
            run_seq(2, $urandom_range(1, 12), ($urandom_range(0, 4) == 0));
        end

        // Reset during LOAD after two words.
        prog_valid = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        for (int w = 0; w < 2; w++) begin
            prog_valid = 1'b1;
            prog_last  = 1'b0;
            prog_data  = DW'($urandom);
            prog_addr  = AW'($urandom);
            prog_hops  = HW'($urandom);
            tick();
        end
        chk("midload_ws", words_sent, 16'd2);
        rst_n      = 1'b0;
        prog_valid = 1'b0;
        tick();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ws", words_sent, 16'd0);
        chk("midrst_call", call, 1'b0);
        chk("midrst_en", instr_en_out, 1'b0);
        chk("midrst_ready", prog_ready, 1'b0);
        chk("midrst_data", instr_data_out, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_no_call", call, 1'b0);
            chk("post_rst_idle", busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/row_instr_loader.md
# row_instr_loader

- One instance per fabric row; it is the initiator end of that row's instruction/call chain.
- Accepts a stream of instruction words from the host over valid/ready and drives each word onto the row's instruction chain inputs with its target hop count.
- After the last word it pulses `call`, then waits for `ret` to fall (cells busy) and rise again (all cells returned), and reports completion.

## Interface
- INSTR_DATA_WIDTH, 32, instruction word width
- INSTR_ADDR_WIDTH, 4, resource address within a cell
- INSTR_HOPS_WIDTH, 4, hop count (target column)
- RET_TIMEOUT, 1024, cycles to wait for `ret` to fall after `call`
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a load-and-call sequence (sampled in IDLE only)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on sequence completion
- err_timeout  out  1  sticky; set when `ret` never fell; cleared by the next accepted `start`
- prog_valid  in  1  host word valid
- prog_ready  out  1  loader accepts word
- prog_data  in  INSTR_DATA_WIDTH  instruction word
- prog_addr  in  INSTR_ADDR_WIDTH  resource address
- prog_hops  in  INSTR_HOPS_WIDTH  hop count
- prog_last  in  1  final word of this sequence
- instr_data_out  out  INSTR_DATA_WIDTH  to chain input, column 0
- instr_addr_out  out  INSTR_ADDR_WIDTH  to chain
- instr_hops_out  out  INSTR_HOPS_WIDTH  to chain
- instr_en_out  out  1  chain word strobe
- call  out  1  to call chain, column 0
- ret  in  1  from ret chain, column 0
- words_sent  out  16  words issued in the current or last sequence; saturates at 0xFFFF

## Operation
- **States:** IDLE, LOAD, CALL, WAIT_LOW, WAIT_HIGH, DONE.
- **IDLE**
  - `prog_ready`=0.
  - On `start`=1: go to LOAD, clear `words_sent` and `err_timeout`.
- **LOAD**
  - `prog_ready`=1.
  - Each handshake (`prog_valid` && `prog_ready`) registers data/addr/hops onto the `instr_*_out` outputs, with `instr_en_out`=1 for exactly the following cycle, and increments `words_sent`.
  - A handshake with `prog_last`=1 moves to CALL.
  - No bubble between words: back-to-back valid gives `instr_en_out` high on consecutive cycles.
- **CALL**
  - `call`=1 for exactly one cycle.
  - Go to WAIT_LOW and load the timeout counter with RET_TIMEOUT-1.
- **WAIT_LOW**
  - `ret`=0: go to WAIT_HIGH.
  - Otherwise the counter decrements.
  - Counter reaches 0 with `ret` still 1: set `err_timeout`, go to DONE.
- **WAIT_HIGH**
  - `ret`=1: go to DONE.
  - No timeout in this state (cells may run arbitrarily long).
- **DONE**
  - `done`=1 for one cycle, then IDLE.
- **Chain outputs when `instr_en_out`=0:** `instr_data_out`/`instr_addr_out`/`instr_hops_out` hold their last value; the chain qualifies by `en`.
- **Zero-length programs:** not supported; every sequence has at least one word.
- **Handshakes outside LOAD:** `prog_valid` in non-LOAD states is ignored and stays unacknowledged.
- **`start` while busy:** ignored.

## Timing
- **Reset** (`rst_n`=0 at clock edge):
  - State IDLE.
  - All outputs 0: `busy`, `done`, `err_timeout`, `prog_ready`, `instr_*_out`, `call`, `words_sent`.
  - Counters 0.
- **Reset mid-sequence:** same as above; partially loaded words are not recalled.
- **Latency:**
  - `start`@t → `busy`=1 and `prog_ready`=1 @t+1.
  - Handshake @t → `instr_en_out`=1 @t+1.
  - Last handshake @t → `call`=1 @t+1.
  - `ret` fall observed in WAIT_LOW @t → WAIT_HIGH @t+1.
  - `ret`=1 in WAIT_HIGH @t → `done`=1 @t+1.
  - `busy`=0 @t+2.
- **`ret`** is sampled as a registered input (the chain is combinational across cells), so every `ret` decision uses the value from the previous cycle.
- **Glitch filter:** a `ret` low pulse of a single cycle counts as a valid fall.
- **Timeout:** `err_timeout` sets exactly RET_TIMEOUT cycles after the `call` cycle.

## Structure
- **Package `row_instr_loader_pkg`:**
  - State enum typedef.
  - Default width constants.
  - Packed instruction struct {hops, addr, data}, shared with the host-side program buffer.
- **Sub-module `ret_waiter`:** the CALL/WAIT_LOW/WAIT_HIGH timeout counter and `ret` input register. It takes `go` and returns `finished`/`timeout`.
- **Top level:** LOAD datapath and top FSM.

## Test plan
- Reset with `prog_valid`=1 → all outputs 0, `prog_ready`=0.
- `start`; 3 back-to-back words (hops 0,1,2; data 0xA,0xB,0xC; last on the third) → `instr_en_out` high 3 consecutive cycles with matching hops/data, `call` pulse the cycle after, `words_sent`=3.
- After `call`:
  - `ret` low for 5 cycles then high → `done` exactly 2 cycles after `ret` rises.
  - `err_timeout`=0.
- `ret` held 1 after `call` with RET_TIMEOUT=8 → `err_timeout`=1 and `done` pulse.
- Next `start` → `err_timeout` clears.
- `prog_valid` toggling 1,0,1 with last → `instr_en_out` 1,0,1.
- `start` during WAIT_HIGH ignored.
- `rst_n`=0 during LOAD after 2 words → IDLE, `words_sent`=0, no `call`.
